// File: rtl/dual_fetch_if_id_if.sv
// Bundle of the fetch-stage signals: hazard masks and redirect in, imem words in, IF/ID state out.
// master = fetch block, slave = surrounding pipeline (hazard unit, imem, decode).
interface dual_fetch_if_id_if #(
    parameter int PC_BITS        = 16,
    parameter int INSTR_BITS     = 32,
    parameter int NUM_PIPE_MASKS = 8,
    parameter int CNT_BITS       = 32
);
    logic [NUM_PIPE_MASKS-1:0] stall0;
    logic [NUM_PIPE_MASKS-1:0] stall1;
    logic [NUM_PIPE_MASKS-1:0] flush0;
    logic [NUM_PIPE_MASKS-1:0] flush1;
    logic                      branch_taken;
    logic [PC_BITS-1:0]        branch_target;
    logic [INSTR_BITS-1:0]     imem_instr0;
    logic [INSTR_BITS-1:0]     imem_instr1;
    logic [PC_BITS-1:0]        pc;
    logic [INSTR_BITS-1:0]     if_id_instr0;
    logic [INSTR_BITS-1:0]     if_id_instr1;
    logic [PC_BITS-1:0]        if_id_pc0;
    logic [PC_BITS-1:0]        if_id_pc1;
    logic                      if_id_valid0;
    logic                      if_id_valid1;
    logic                      first;
    logic [CNT_BITS-1:0]       stall_cycles;

    modport master (
        input  stall0, stall1, flush0, flush1, branch_taken, branch_target,
               imem_instr0, imem_instr1,
        output pc, if_id_instr0, if_id_instr1, if_id_pc0, if_id_pc1,
               if_id_valid0, if_id_valid1, first, stall_cycles
    );

    modport slave (
        output stall0, stall1, flush0, flush1, branch_taken, branch_target,
               imem_instr0, imem_instr1,
        input  pc, if_id_instr0, if_id_instr1, if_id_pc0, if_id_pc1,
               if_id_valid0, if_id_valid1, first, stall_cycles
    );
endinterface

// File: rtl/dual_fetch_if_id.sv
// Dual-lane fetch: PC register and IF/ID lane registers driven by per-lane stall/flush masks.
// Latency 1 cycle imem->IF/ID; stalled lanes hold, flushed lanes become invalid NOPs.
module dual_fetch_if_id #(
    parameter int PC_BITS        = 16,
    parameter int INSTR_BITS     = 32,
    parameter int NUM_PIPE_MASKS = 8,
    parameter int CNT_BITS       = 32
) (
    input  logic                clk,
    input  logic                reset,
    dual_fetch_if_id_if.master  bus
);
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC    = NUM_PIPE_MASKS'(1);
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID = NUM_PIPE_MASKS'(2);

    logic s0, s1, f0, f1, pc_stall, bt;

    logic [PC_BITS-1:0]    pc_q;
    logic [INSTR_BITS-1:0] instr0_q, instr1_q;
    logic [PC_BITS-1:0]    pc0_q, pc1_q;
    logic                  valid0_q, valid1_q;
    logic                  first_q;
    logic [CNT_BITS-1:0]   cnt_q;

    assign s0       = (bus.stall0 & PIPE_REG_IF_ID) != '0;
    assign s1       = (bus.stall1 & PIPE_REG_IF_ID) != '0;
    assign f0       = (bus.flush0 & PIPE_REG_IF_ID) != '0;
    assign f1       = (bus.flush1 & PIPE_REG_IF_ID) != '0;
    assign pc_stall = ((bus.stall0 | bus.stall1) & PIPE_REG_PC) != '0;
    assign bt       = bus.branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (bt)
                pc_q <= bus.branch_target;
            else if (!pc_stall)
                pc_q <= pc_q + PC_BITS'(2);

            // Flush beats stall on the same lane; the pc field is left as-is when killed.
            if (bt || f0) begin
                instr0_q <= '0;
                valid0_q <= 1'b0;
            end else if (!s0) begin
                instr0_q <= bus.imem_instr0;
                pc0_q    <= pc_q;
                valid0_q <= 1'b1;
            end

            if (bt || f1) begin
                instr1_q <= '0;
                valid1_q <= 1'b0;
            end else if (!s1) begin
                instr1_q <= bus.imem_instr1;
                pc1_q    <= pc_q + PC_BITS'(1);
                valid1_q <= 1'b1;
            end

            // A lone held lane keeps the older instruction, so lane order follows it.
            if (bt)
                first_q <= 1'b0;
            else if (s0 && !f0 && f1)
                first_q <= 1'b0;
            else if (s1 && !f1 && f0)
                first_q <= 1'b1;
            else if (!s0 && !f0 && !s1 && !f1)
                first_q <= 1'b0;

            if (pc_stall && !bt && cnt_q != '1)
                cnt_q <= cnt_q + CNT_BITS'(1);
        end
    end

    assign bus.pc           = pc_q;
    assign bus.if_id_instr0 = instr0_q;
    assign bus.if_id_instr1 = instr1_q;
    assign bus.if_id_pc0    = pc0_q;
    assign bus.if_id_pc1    = pc1_q;
    assign bus.if_id_valid0 = valid0_q;
    assign bus.if_id_valid1 = valid1_q;
    assign bus.first        = first_q;
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_dual_fetch_if_id.sv
// Directed bench for dual_fetch_if_id: lane-outcome model checked every cycle, plus literal spot checks.
module tb_dual_fetch_if_id;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  stall0 = '0, stall1 = '0, flush0 = '0, flush1 = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [15:0] a);
        return {16'hBEEF ^ a, a};
    endfunction

    dual_fetch_if_id_if #(.CNT_BITS(32)) bus_a ();
    dual_fetch_if_id_if #(.CNT_BITS(3))  bus_b ();

    assign bus_a.stall0 = stall0;  assign bus_b.stall0 = stall0;
    assign bus_a.stall1 = stall1;  assign bus_b.stall1 = stall1;
    assign bus_a.flush0 = flush0;  assign bus_b.flush0 = flush0;
    assign bus_a.flush1 = flush1;  assign bus_b.flush1 = flush1;
    assign bus_a.branch_taken  = branch_taken;  assign bus_b.branch_taken  = branch_taken;
    assign bus_a.branch_target = branch_target; assign bus_b.branch_target = branch_target;
    assign bus_a.imem_instr0 = word(bus_a.pc);
    assign bus_a.imem_instr1 = word(bus_a.pc + 16'd1);
    assign bus_b.imem_instr0 = word(bus_b.pc);
    assign bus_b.imem_instr1 = word(bus_b.pc + 16'd1);

    dual_fetch_if_id #(.CNT_BITS(32)) dut   (.clk(clk), .reset(rst), .bus(bus_a));
    dual_fetch_if_id #(.CNT_BITS(3))  dut_s (.clk(clk), .reset(rst), .bus(bus_b));

    // Reference model: each lane resolves to Killed, Held or Loaded per cycle.
    typedef enum {KILL, HOLD, LOAD} outcome_t;
    logic [15:0] m_pc, m_pc0, m_pc1;
    logic [31:0] m_i0, m_i1;
    logic        m_v0, m_v1, m_first;
    longint      m_cnt, m_cnt_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_pc0 = 0; m_pc1 = 0; m_i0 = 0; m_i1 = 0;
            m_v0 = 0; m_v1 = 0; m_first = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            outcome_t o0, o1;
            bit pcs;
            pcs = stall0[0] || stall1[0];
            o0 = (branch_taken || flush0[1]) ? KILL : (stall0[1] ? HOLD : LOAD);
            o1 = (branch_taken || flush1[1]) ? KILL : (stall1[1] ? HOLD : LOAD);
            if (o0 == KILL) begin m_i0 = 0; m_v0 = 0; end
            else if (o0 == LOAD) begin m_i0 = word(m_pc); m_pc0 = m_pc; m_v0 = 1; end
            if (o1 == KILL) begin m_i1 = 0; m_v1 = 0; end
            else if (o1 == LOAD) begin m_i1 = word(m_pc + 16'd1); m_pc1 = m_pc + 16'd1; m_v1 = 1; end
            if (branch_taken) m_first = 0;
            else if (o0 == HOLD && o1 == KILL) m_first = 0;
            else if (o0 == KILL && o1 == HOLD) m_first = 1;
            else if (o0 == LOAD && o1 == LOAD) m_first = 0;
            if (pcs && !branch_taken) begin
                m_cnt   = (m_cnt   < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
                m_cnt_s = (m_cnt_s < 7)              ? m_cnt_s + 1 : m_cnt_s;
            end
            m_pc = branch_taken ? branch_target : (pcs ? m_pc : m_pc + 16'd2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pc",     64'(bus_a.pc),           64'(m_pc));
        chk("instr0", 64'(bus_a.if_id_instr0), 64'(m_i0));
        chk("instr1", 64'(bus_a.if_id_instr1), 64'(m_i1));
        chk("pc0",    64'(bus_a.if_id_pc0),    64'(m_pc0));
        chk("pc1",    64'(bus_a.if_id_pc1),    64'(m_pc1));
        chk("valid0", 64'(bus_a.if_id_valid0), 64'(m_v0));
        chk("valid1", 64'(bus_a.if_id_valid1), 64'(m_v1));
        chk("first",  64'(bus_a.first),        64'(m_first));
        chk("stall_cycles",   64'(bus_a.stall_cycles), 64'(m_cnt));
        chk("stall_cycles_s", 64'(bus_b.stall_cycles), 64'(m_cnt_s));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [7:0] s0, s1, f0, f1, input logic bt, input logic [15:0] tgt);
        stall0 = s0; stall1 = s1; flush0 = f0; flush1 = f1;
        branch_taken = bt; branch_target = tgt;
    endtask

    initial begin
        step(2);
        chk("lit_reset_pc",    64'(bus_a.pc), 64'h0);
        chk("lit_reset_valid", 64'({bus_a.if_id_valid0, bus_a.if_id_valid1}), 64'h0);
        rst = 1'b0;

        // Free-running fetch: pc 0,2,4,6; IF/ID shows the pair fetched at 4.
        drive(0, 0, 0, 0, 0, 0);
        step(3);
        chk("lit_run_pc",     64'(bus_a.pc), 64'h6);
        chk("lit_run_pc0",    64'(bus_a.if_id_pc0), 64'h4);
        chk("lit_run_instr1", 64'(bus_a.if_id_instr1), 64'hBEEA_0005);
        chk("lit_run_valid",  64'({bus_a.if_id_valid0, bus_a.if_id_valid1}), 64'h3);

        // Load-use stall for two cycles, ID_EX flush bits ignored here.
        drive(3, 3, 4, 4, 0, 0);
        step(2);
        chk("lit_lu_pc",  64'(bus_a.pc), 64'h6);
        chk("lit_lu_pc0", 64'(bus_a.if_id_pc0), 64'h4);
        chk("lit_lu_cnt", 64'(bus_a.stall_cycles), 64'h2);
        drive(0, 0, 0, 0, 0, 0);
        step(1);
        chk("lit_lu_resume", 64'(bus_a.pc), 64'h8);

        // Split: lane0 held, lane1 flushed.
        drive(3, 1, 4, 2, 0, 0);
        step(1);
        chk("lit_split0_v1",    64'(bus_a.if_id_valid1), 64'h0);
        chk("lit_split0_first", 64'(bus_a.first), 64'h0);
        chk("lit_split0_pc",    64'(bus_a.pc), 64'h8);
        // Split swapped.
        drive(1, 3, 2, 4, 0, 0);
        step(1);
        chk("lit_split1_first", 64'(bus_a.first), 64'h1);
        chk("lit_split1_v0",    64'(bus_a.if_id_valid0), 64'h0);

        // Redirect wins over stall; stall counter unaffected.
        drive(3, 0, 0, 0, 1, 16'h0040);
        step(1);
        chk("lit_br_pc",    64'(bus_a.pc), 64'h40);
        chk("lit_br_valid", 64'({bus_a.if_id_valid0, bus_a.if_id_valid1}), 64'h0);
        chk("lit_br_first", 64'(bus_a.first), 64'h0);
        chk("lit_br_cnt",   64'(bus_a.stall_cycles), 64'h4);

        // ID_EX-only masks have no effect.
        drive(4, 4, 4, 4, 0, 0);
        step(1);
        chk("lit_idex_pc", 64'(bus_a.pc), 64'h42);

        // PC wrap.
        drive(0, 0, 0, 0, 1, 16'hFFFE);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(1);
        chk("lit_wrap_pc",  64'(bus_a.pc), 64'h0);
        chk("lit_wrap_pc1", 64'(bus_a.if_id_pc1), 64'hFFFF);
        chk("lit_wrap_pc0", 64'(bus_a.if_id_pc0), 64'hFFFE);

        // Saturation on the narrow-counter instance.
        drive(1, 0, 0, 0, 0, 0);
        step(10);
        chk("lit_sat_small", 64'(bus_b.stall_cycles), 64'h7);
        chk("lit_sat_big",   64'(bus_a.stall_cycles), 64'd14);

        // Async reset mid-cycle during a split stall.
        drive(1, 3, 2, 4, 0, 0);
        step(1);
        chk("lit_pre_rst_first", 64'(bus_a.first), 64'h1);
        rst = 1'b1;
        #1;
        chk("lit_arst_pc",    64'(bus_a.pc), 64'h0);
        chk("lit_arst_first", 64'(bus_a.first), 64'h0);
        chk("lit_arst_cnt",   64'(bus_a.stall_cycles), 64'h0);
        chk("lit_arst_instr", 64'({bus_a.if_id_instr0, bus_a.if_id_instr1}), 64'h0);
        chk("lit_arst_v",     64'({bus_a.if_id_valid0, bus_a.if_id_valid1}), 64'h0);
        step(1);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step(2);
        chk("lit_post_rst_pc", 64'(bus_a.pc), 64'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_fetch_if_id.md
Name: dual_fetch_if_id

Overview:
- Fetch-side consumer of the dual-lane stall/flush masks produced by hazard detection.
- Owns the PC register, both IF/ID lane registers (instruction, pc, valid) and the lane-order bit `first`, which feeds back into hazard detection.
- Sits between instruction memory and the decode stage.
- Applies per-lane PC/IF_ID stall and flush bits, taken-branch redirects, and counts stall cycles.

Parameters:
- PC_BITS, 16, width of PC and lane pc fields.
- INSTR_BITS, 32, instruction word width.
- NUM_PIPE_MASKS, 8, mask width. Bit encoding: PIPE_REG_PC=1, PIPE_REG_IF_ID=2, PIPE_REG_ID_EX=4.
- CNT_BITS, 32, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- stall0  in  NUM_PIPE_MASKS  lane0 stall mask
- stall1  in  NUM_PIPE_MASKS  lane1 stall mask
- flush0  in  NUM_PIPE_MASKS  lane0 flush mask
- flush1  in  NUM_PIPE_MASKS  lane1 flush mask
- branch_taken  in  1  EX-stage redirect
- branch_target  in  PC_BITS  redirect address
- imem_instr0  in  INSTR_BITS  word at pc, combinational from imem
- imem_instr1  in  INSTR_BITS  word at pc+1
- pc  out  PC_BITS  fetch address
- if_id_instr0  out  INSTR_BITS  lane0 IF/ID instruction
- if_id_instr1  out  INSTR_BITS  lane1 IF/ID instruction
- if_id_pc0  out  PC_BITS  lane0 IF/ID pc
- if_id_pc1  out  PC_BITS  lane1 IF/ID pc
- if_id_valid0  out  1  lane0 holds a real instruction
- if_id_valid1  out  1  lane1 holds a real instruction
- first  out  1  1 = lane1 holds the older instruction
- stall_cycles  out  CNT_BITS  saturating stall count

Behaviour:
- All state is registered on posedge clk; reset forces it immediately, including mid-cycle.
- Reset values: pc=0, instr0/1=0 (NOP word), pc0/1=0, valid0/1=0, first=0, stall_cycles=0.
- A lane's stall bit = mask & PIPE_REG_IF_ID != 0; a lane's flush bit is decoded the same way from its flush mask.
- pc_stall = (stall0|stall1) & PIPE_REG_PC != 0.
- Next pc, in priority order:
  - branch_taken: branch_target.
  - pc_stall: hold.
  - otherwise: pc+2, wrapping modulo 2^PC_BITS (0xFFFE -> 0x0000).
- Per-lane IF/ID update, highest priority first:
  - branch_taken: instr=0, valid=0, pc held.
  - Lane flush bit: instr=0, valid=0, pc held. If the same lane has both stall and flush bits, flush wins.
  - Lane stall bit: hold all fields.
  - Otherwise load: lane0 gets imem_instr0 with pc0=pc; lane1 gets imem_instr1 with pc1=pc+1 (wrapping). Both set valid=1.
- `first` update, highest priority first:
  - branch_taken: 0.
  - Split with lane0 stalled and lane1 flushed: 0.
  - Split with lane1 stalled and lane0 flushed: 1.
  - Both lanes load: 0.
  - Any other combination: hold.
- Latency: one cycle from imem word to the IF/ID outputs.
- A held lane is presented unchanged for every cycle its stall bit is set.
- stall_cycles increments by 1 in each cycle where pc_stall=1 and branch_taken=0. It saturates at all-ones and never wraps.
- Masks with only ID_EX bits set are ignored by this block.
- Output ports are driven directly from registers, with no combinational path from inputs.

Test Plan:
- Reset then 3 clocks, no stalls, imem words A0/A1, B0/B1, C0/C1 -> pc 0, 2, 4, 6; IF/ID shows A pair (pc0=0, pc1=1), then B, then C; valid=11; first=0.
- Load-use stall: stall0=stall1=3, flush0=flush1=4 for 2 cycles at pc=4 -> pc holds 4, IF/ID unchanged, stall_cycles=2, then resumes at 6.
- Split with lane0 held: stall0=3, flush0=4, stall1=1, flush1=2 -> lane0 held; lane1 instr=0, valid1=0; first=0; pc held. Same split with lanes swapped -> first=1.
- Redirect during stall: branch_taken=1, branch_target=0x0040, stall0=3 -> pc=0x0040, both lanes NOP and invalid, first=0, stall_cycles unchanged.
- Wrap and saturation: pc=0xFFFE with no stall -> pc=0x0000 and pc1=0xFFFF. stall_cycles preset to 0xFFFFFFFF with stall held -> stays 0xFFFFFFFF.
- Async reset asserted mid-cycle during a split stall -> all outputs take reset values before the next clk edge.
